branch_checkpoint_alloc: RTL

//  Dispatch-side writer for the branch stack. Allocates one free B_MASK bit per dispatched branch/jump (lowest free first, program order).

---
 rtl/branch_checkpoint_alloc_pkg.sv | 65 ++++++
 rtl/branch_checkpoint_alloc_if.sv | 36 +++
 rtl/branch_checkpoint_alloc_bmask_free_picker.sv | 20 ++
 rtl/branch_checkpoint_alloc.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/branch_checkpoint_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Module : branch_checkpoint_alloc_pkg
// Brief  : Shared types for the dispatch-side branch checkpoint allocator.
// Rev    : 1.0
// ============================================================================
package branch_checkpoint_alloc_pkg;

  localparam int N              = 3;
  localparam int B_MASK_WIDTH   = 4;
  localparam int ADDR_W         = 32;
  localparam int PHYS_REGS      = 16;
  localparam int PHYS_REG_IDX_W = $clog2(PHYS_REGS);
  localparam int ARCH_REGS      = 4;
  localparam int ROB_IDX_W      = 4;

  typedef logic [B_MASK_WIDTH-1:0]   B_MASK;
  typedef logic [ADDR_W-1:0]         ADDR;
  typedef logic [PHYS_REG_IDX_W-1:0] PHYS_REG_IDX;
  typedef PHYS_REG_IDX [ARCH_REGS-1:0] MAP_TABLE;
  typedef logic [PHYS_REGS-1:0]      FREE_LIST;
  typedef logic [ROB_IDX_W-1:0]      ROB_IDX;

  typedef struct packed {
    logic taken;
    ADDR  target;
  } BP_PACKET;

  // Snapshot handed over by rename for each dispatch slot.
  typedef struct packed {
    logic     is_jump;
    ADDR      original_pc;
    ADDR      recovery_pc;
    BP_PACKET bp_packet;
    ROB_IDX   rob_tail;
    MAP_TABLE map_table;
    FREE_LIST free_list;
  } BS_REQ_PACKET;

  typedef struct packed {
    logic     valid;
    B_MASK    b_m;
    logic     is_jump;
    ADDR      original_pc;
    ADDR      recovery_pc;
    BP_PACKET bp_packet;
    ROB_IDX   rob_tail;
    MAP_TABLE map_table;
    FREE_LIST free_list;
  } BS_ENTRY_PACKET;

  typedef enum logic [0:0] {
    BCA_NORMAL  = 1'b0,
    BCA_RECOVER = 1'b1
  } BCA_STATE;

  function automatic int unsigned popcount(input B_MASK m);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < B_MASK_WIDTH; i++) cnt += {31'd0, m[i]};
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_checkpoint_alloc_if.sv
`default_nettype none
// ============================================================================
// Module : branch_checkpoint_alloc_if
// Brief  : Dispatch/branch-stack signal bundle around the checkpoint allocator.
// Rev    : 1.0
// ============================================================================
interface branch_checkpoint_alloc_if
  import branch_checkpoint_alloc_pkg::*;
#(
  parameter int DW = N,
  parameter int MW = B_MASK_WIDTH
) ();

  logic [DW-1:0]              disp_valid;
  logic [DW-1:0]              disp_is_br;
  BS_REQ_PACKET [DW-1:0]      disp_req;
  B_MASK                      b_mask_combinational;
  logic                       restore_valid;
  BS_ENTRY_PACKET [MW-1:0]    branch_stack_entries;
  B_MASK                      next_b_mask;
  B_MASK [DW-1:0]             inst_b_mask;
  logic [$clog2(DW+1)-1:0]    dispatch_limit;
  logic                       bs_full;

  modport master (
    output disp_valid, disp_is_br, disp_req, b_mask_combinational, restore_valid,
    input  branch_stack_entries, next_b_mask, inst_b_mask, dispatch_limit, bs_full
  );

  modport slave (
    input  disp_valid, disp_is_br, disp_req, b_mask_combinational, restore_valid,
    output branch_stack_entries, next_b_mask, inst_b_mask, dispatch_limit, bs_full
  );

endinterface
`default_nettype wire

// File: rtl/branch_checkpoint_alloc_bmask_free_picker.sv
`default_nettype none
// ============================================================================
// Module : bmask_free_picker
// Brief  : Lowest-set-bit priority picker over an available-checkpoint mask.
// Rev    : 1.0
// ============================================================================
module bmask_free_picker #(
  parameter int W = 4
) (
  input  logic [W-1:0] avail,
  output logic [W-1:0] grant,
  output logic         found
);

  // Two's-complement isolate of the lowest set bit.
  assign grant = avail & (~avail + W'(1));
  assign found = |avail;

endmodule
`default_nettype wire

// File: rtl/branch_checkpoint_alloc.sv
`default_nettype none
// ============================================================================
// Module : branch_checkpoint_alloc
// Brief  : Grants B_MASK checkpoints to dispatched branches and throttles dispatch.
// Rev    : 1.0
// ============================================================================
module branch_checkpoint_alloc
  import branch_checkpoint_alloc_pkg::*;
#(
  parameter int DISPATCH_WIDTH = N,
  parameter int MASK_W         = B_MASK_WIDTH
) (
  input logic                      clock,
  input logic                      reset,
  branch_checkpoint_alloc_if.slave bca
);

  localparam int c_limit_w = $clog2(DISPATCH_WIDTH + 1);
  localparam int c_cnt_w   = $clog2(MASK_W + 1);

  BCA_STATE              r_state;
  BCA_STATE              w_state_next;
  B_MASK                 r_alloc_mask;
  logic [c_cnt_w-1:0]    r_outst_cnt;

  B_MASK                 w_free;
  logic                  w_alloc_en;
  B_MASK                 w_grant     [DISPATCH_WIDTH];
  B_MASK                 w_inst_mask [DISPATCH_WIDTH];
  logic                  w_stall     [DISPATCH_WIDTH];
  B_MASK                 w_all_grants;
  B_MASK                 w_next_mask;
  logic [c_limit_w-1:0]  w_limit;
  BS_ENTRY_PACKET [MASK_W-1:0] w_entries;

  assign w_free     = ~bca.b_mask_combinational;
  assign w_alloc_en = !reset && (r_state == BCA_NORMAL) && !bca.restore_valid;

  // Slot chain: each slot picks from whatever the older slots left over.
  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_slot
    B_MASK w_avail_in;
    B_MASK w_pick;
    B_MASK w_older;
    logic  w_found;
    logic  w_stop_in;
    logic  w_is_br;

    if (k == 0) begin : g_first
      assign w_avail_in = w_free;
      assign w_stop_in  = 1'b0;
      assign w_older    = '0;
    end else begin : g_next
      assign w_avail_in = g_slot[k-1].w_avail_in & ~w_grant[k-1];
      assign w_stop_in  = g_slot[k-1].w_stop_in | w_stall[k-1];
      assign w_older    = g_slot[k-1].w_older | w_grant[k-1];
    end

    bmask_free_picker #(
      .W (MASK_W)
    ) u_picker (
      .avail (w_avail_in),
      .grant (w_pick),
      .found (w_found)
    );

    assign w_is_br        = bca.disp_valid[k] & bca.disp_is_br[k];
    assign w_stall[k]     = w_alloc_en & ~w_stop_in & w_is_br & ~w_found;
    assign w_grant[k]     = (w_alloc_en && !w_stop_in && w_is_br) ? w_pick : '0;
    assign w_inst_mask[k] = reset ? '0 : (bca.b_mask_combinational | w_older);
  end

  always_comb begin
    w_all_grants = '0;
    w_limit      = w_alloc_en ? c_limit_w'(DISPATCH_WIDTH) : '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      w_all_grants = w_all_grants | w_grant[k];
    end
    // Walk youngest to oldest so the oldest stalling branch sets the limit.
    for (int k = DISPATCH_WIDTH - 1; k >= 0; k--) begin
      if (w_stall[k]) w_limit = c_limit_w'(k);
    end
  end

  assign w_next_mask = reset ? '0 : (bca.b_mask_combinational | w_all_grants);

  always_comb begin
    w_entries = '0;
    for (int b = 0; b < MASK_W; b++) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (w_grant[k][b]) begin
          w_entries[b].valid       = 1'b1;
          w_entries[b].b_m         = w_inst_mask[k];
          w_entries[b].is_jump     = bca.disp_req[k].is_jump;
          w_entries[b].original_pc = bca.disp_req[k].original_pc;
          w_entries[b].recovery_pc = bca.disp_req[k].recovery_pc;
          w_entries[b].bp_packet   = bca.disp_req[k].bp_packet;
          w_entries[b].rob_tail    = bca.disp_req[k].rob_tail;
          w_entries[b].map_table   = bca.disp_req[k].map_table;
          w_entries[b].free_list   = bca.disp_req[k].free_list;
        end
      end
    end
  end

  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_tag
    assign bca.inst_b_mask[k] = w_inst_mask[k];
  end

  assign bca.branch_stack_entries = w_entries;
  assign bca.next_b_mask          = w_next_mask;
  assign bca.dispatch_limit       = w_limit;
  assign bca.bs_full              = !reset && (w_free == '0);

  // A restore arriving in RECOVER extends recovery by another cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BCA_NORMAL:  if (bca.restore_valid) w_state_next = BCA_RECOVER;
      BCA_RECOVER: if (!bca.restore_valid) w_state_next = BCA_NORMAL;
      default:     w_state_next = BCA_NORMAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= BCA_NORMAL;
      r_alloc_mask <= '0;
      r_outst_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_alloc_mask <= w_next_mask;
      r_outst_cnt  <= c_cnt_w'(popcount(w_next_mask));
    end
  end

  // Resolves and restores only clear bits, so the live mask never exceeds ours.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int j = 0; j < DISPATCH_WIDTH; j++) begin
        for (int k = j + 1; k < DISPATCH_WIDTH; k++) begin
          assert ((w_grant[j] & w_grant[k]) == '0);
        end
      end
      assert ((w_all_grants & bca.b_mask_combinational) == '0);
      if (r_state == BCA_NORMAL && !bca.restore_valid) begin
        assert ((bca.b_mask_combinational & ~r_alloc_mask) == '0);
      end
      assert (r_outst_cnt == c_cnt_w'(popcount(r_alloc_mask)));
    end
  end

endmodule
`default_nettype wire
